// File: rtl/stream_scheduler.sv
// Round-robin scheduler that gates the Fibonacci and timer generators and
// funnels their words through one-word skid slots into the CDC buffer write port.
module stream_scheduler #(
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int MAX_WORDS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_f,
  input  logic          start_t,
  input  logic          stop,
  input  logic          f_valid,
  input  logic [DW-1:0] f_data,
  input  logic          t_valid,
  input  logic [DW-1:0] t_data,
  input  logic          buf_full,
  input  logic          buf_empty,
  input  logic          rd_valid,
  output logic          f_en,
  output logic          t_en,
  output logic          wr_en,
  output logic [DW-1:0] wr_data,
  output logic          wr_src,
  output logic          parity,
  output logic [CW-1:0] word_cnt,
  output logic          ovf,
  output logic          busy,
  output logic [1:0]    state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_WAIT  = 2'b10;
  localparam logic [1:0] S_DRAIN = 2'b11;

  logic [1:0]    state_q, state_d;
  logic          f_act_q, f_act_d, t_act_q, t_act_d;
  logic          f_en_q, f_en_d, t_en_q, t_en_d;
  logic          sf_q, sf_d, st_q, st_d;
  logic [DW-1:0] df_q, df_d, dt_q, dt_d;
  logic          rr_q, rr_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          ovf_q, ovf_d;

  logic          is_idle, sel_t, wr_en_c, free_f, free_t, auto_stop;
  logic [DW-1:0] wr_data_c;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    is_idle   = (state_q == S_IDLE);
    sel_t     = st_q & (~sf_q | rr_q);
    wr_en_c   = ~is_idle & ~buf_full & (sf_q | st_q);
    wr_data_c = wr_en_c ? (sel_t ? dt_q : df_q) : '0;
    free_f    = wr_en_c & ~sel_t;
    free_t    = wr_en_c & sel_t;
    cnt_inc   = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + CW'(1);
    auto_stop = (MAX_WORDS != 0) && wr_en_c && (cnt_inc == CW'(MAX_WORDS));

    state_d    = state_q;
    f_act_d    = f_act_q;
    t_act_d    = t_act_q;
    f_en_d     = 1'b0;
    t_en_d     = 1'b0;
    sf_d       = sf_q;
    st_d       = st_q;
    df_d       = df_q;
    dt_d       = dt_q;
    rr_d       = rr_q;
    parity_d   = parity_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;

    if (wr_en_c) begin
      parity_d   = ^wr_data_c;
      word_cnt_d = cnt_inc;
      if (sf_q && st_q) rr_d = ~rr_q;
    end

    if (!is_idle) begin
      if (free_f) sf_d = 1'b0;
      if (free_t) st_d = 1'b0;
      if (f_valid) begin
        if (sf_q && !free_f) ovf_d = 1'b1;
        else begin
          sf_d = 1'b1;
          df_d = f_data;
        end
      end
      if (t_valid) begin
        if (st_q && !free_t) ovf_d = 1'b1;
        else begin
          st_d = 1'b1;
          dt_d = t_data;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_f || start_t) begin
          f_act_d    = start_f;
          t_act_d    = start_t;
          word_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        f_act_d = f_act_q | start_f;
        t_act_d = t_act_q | start_t;
        f_en_d  = f_act_q;
        t_en_d  = t_act_q;
        if (stop || auto_stop) state_d = S_DRAIN;
        else if (buf_full)     state_d = S_WAIT;
      end
      S_WAIT: begin
        f_act_d = f_act_q | start_f;
        t_act_d = t_act_q | start_t;
        if (stop || auto_stop) state_d = S_DRAIN;
        else if (!buf_full)    state_d = S_RUN;
      end
      default: begin
        f_act_d = 1'b0;
        t_act_d = 1'b0;
        // Use next-cycle slot occupancy so a word arriving on the exit cycle is not stranded in IDLE.
        if (!sf_d && !st_d && buf_empty && !rd_valid) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      f_act_q    <= 1'b0;
      t_act_q    <= 1'b0;
      f_en_q     <= 1'b0;
      t_en_q     <= 1'b0;
      sf_q       <= 1'b0;
      st_q       <= 1'b0;
      df_q       <= '0;
      dt_q       <= '0;
      rr_q       <= 1'b0;
      parity_q   <= 1'b0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_act_q    <= f_act_d;
      t_act_q    <= t_act_d;
      f_en_q     <= f_en_d;
      t_en_q     <= t_en_d;
      sf_q       <= sf_d;
      st_q       <= st_d;
      df_q       <= df_d;
      dt_q       <= dt_d;
      rr_q       <= rr_d;
      parity_q   <= parity_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign f_en     = f_en_q;
  assign t_en     = t_en_q;
  assign wr_en    = wr_en_c;
  assign wr_data  = wr_data_c;
  assign wr_src   = wr_en_c & sel_t;
  assign parity   = parity_q;
  assign word_cnt = word_cnt_q;
  assign ovf      = ovf_q;
  assign busy     = ~is_idle;
  assign state    = state_q;

endmodule
